// File: rtl/audio_mixer_sd.sv
// Multi-channel audio mixer: a time-multiplexed volume MAC started by ce, with a
// saturated PCM output and a first-order sigma-delta 1-bit DAC.
module audio_mixer_term #(
  parameter int DW = 6,
  parameter int VW = 4
) (
  input  logic [DW-1:0] data,
  input  logic [VW-1:0] vol,
  input  logic          mute,
  output logic [DW-1:0] term
);
  logic [DW+VW-1:0] prod;

  // 2^VW-1 is close to unity gain, so the product is scaled back down by 2^VW.
  always_comb begin
    prod = {{VW{1'b0}}, data} * {{DW{1'b0}}, vol};
    term = mute ? '0 : DW'(prod >> VW);
  end
endmodule

module audio_mixer_sd #(
  parameter int CHANNELS = 4,
  parameter int DW       = 6,
  parameter int VW       = 4,
  parameter int OW       = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   tape,
  input  logic [CHANNELS*DW-1:0] ch_data,
  input  logic [CHANNELS*VW-1:0] ch_vol,
  input  logic [CHANNELS-1:0]    ch_mute,
  output logic [OW-1:0]          sample,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   q
);
  localparam int AW = DW + $clog2(CHANNELS + 1) + 1;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = ((AW > OW) ? AW : OW) + 1;

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t                       state_q, state_d;
  logic [CHANNELS-1:0][DW-1:0]  data_q, data_d;
  logic [CHANNELS-1:0][VW-1:0]  vol_q, vol_d;
  logic [CHANNELS-1:0]          mute_q, mute_d;
  logic [CHANNELS-1:0][DW-1:0]  term;
  logic [IW-1:0]                idx_q, idx_d;
  logic [AW-1:0]                acc_q, acc_d;
  logic [OW-1:0]                sample_q, sample_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;
  logic [OW-1:0]                sd_q, sd_d;
  logic                         q_q, q_d;
  logic                         last;

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_lane
    audio_mixer_term #(.DW(DW), .VW(VW)) u_term (
      .data(data_q[i]),
      .vol (vol_q[i]),
      .mute(mute_q[i]),
      .term(term[i])
    );
  end

  assign last = (idx_q == IW'(CHANNELS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ce) state_d = SUM;
      SUM:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    sample       = sample_q;
    sample_valid = valid_q;
    overrun      = overrun_q;
    q            = q_q;
  end

  // Inputs are snapshotted at start so mid-mix changes cannot disturb the sum.
  always_comb begin
    data_d    = data_q;
    vol_d     = vol_q;
    mute_d    = mute_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (ce & (state_q != IDLE));
    case (state_q)
      IDLE: if (ce) begin
        data_d = ch_data;
        vol_d  = ch_vol;
        mute_d = ch_mute;
        idx_d  = '0;
        acc_d  = tape ? AW'({DW{1'b1}}) : '0;
      end
      SUM: begin
        acc_d = acc_q + AW'(term[idx_q]);
        idx_d = last ? '0 : idx_q + 1'b1;
      end
      DONE: begin
        sample_d = (CW'(acc_q) > CW'({OW{1'b1}})) ? '1 : OW'(acc_q);
        valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Carry out of the OW-bit phase accumulator is the 1-bit DAC stream.
  always_comb begin
    {q_d, sd_d} = {1'b0, sd_q} + {1'b0, sample_q};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      vol_q     <= '0;
      mute_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sd_q      <= '0;
      q_q       <= 1'b0;
    end else begin
      data_q    <= data_d;
      vol_q     <= vol_d;
      mute_q    <= mute_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sd_q      <= sd_d;
      q_q       <= q_d;
    end
  end
endmodule

// File: tb/tb_audio_mixer_sd.sv
// Bench for audio_mixer_sd: directed and random mixes against an arithmetic
// reference, overrun/reset behaviour and sigma-delta density.
module tb_audio_mixer_sd;
  localparam int C   = 4;
  localparam int DW  = 6;
  localparam int VW  = 4;
  localparam int DWT = C * DW;
  localparam int VWT = C * VW;

  logic clock = 1'b0, reset = 1'b0, ce = 1'b0, tape = 1'b0;
  logic [DWT-1:0] ch_data = '0;
  logic [VWT-1:0] ch_vol = '0;
  logic [C-1:0]   ch_mute = '0;
  logic [9:0] sample;
  logic       sample_valid, busy, overrun, q;
  logic [7:0] sample8;
  logic       sv8, busy8, ov8, q8;

  logic        ce_b = 1'b0, tape_b = 1'b0;
  logic [31:0] data_b = '0;
  logic [15:0] vol_b = '0;
  logic [3:0]  mute_b = '0;
  logic [9:0]  sample_b;
  logic        sv_b, busy_b, ov_b, q_b;

  int d[C], v[C];
  bit m[C];
  bit tp;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  audio_mixer_sd dut (
    .clock(clock), .reset(reset), .ce(ce), .tape(tape), .ch_data(ch_data),
    .ch_vol(ch_vol), .ch_mute(ch_mute), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .overrun(overrun), .q(q));

  audio_mixer_sd #(.OW(8)) dut8 (
    .clock(clock), .reset(reset), .ce(ce), .tape(tape), .ch_data(ch_data),
    .ch_vol(ch_vol), .ch_mute(ch_mute), .sample(sample8), .sample_valid(sv8),
    .busy(busy8), .overrun(ov8), .q(q8));

  audio_mixer_sd #(.CHANNELS(4), .DW(8), .VW(4), .OW(10)) dutb (
    .clock(clock), .reset(reset), .ce(ce_b), .tape(tape_b), .ch_data(data_b),
    .ch_vol(vol_b), .ch_mute(mute_b), .sample(sample_b), .sample_valid(sv_b),
    .busy(busy_b), .overrun(ov_b), .q(q_b));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sum of volume-scaled unmuted channels plus full-scale tape, clipped to OW bits.
  function automatic int ref_mix(int ow);
    int s = tp ? (1 << DW) - 1 : 0;
    for (int i = 0; i < C; i++) if (!m[i]) s += (d[i] * v[i]) / (1 << VW);
    return (s > (1 << ow) - 1) ? (1 << ow) - 1 : s;
  endfunction

  task automatic apply();
    for (int i = 0; i < C; i++) begin
      ch_data[i*DW +: DW] = DW'(d[i]);
      ch_vol[i*VW +: VW]  = VW'(v[i]);
      ch_mute[i]          = m[i];
    end
    tape = tp;
  endtask

  task automatic scramble();
    ch_data = DWT'($urandom);
    ch_vol  = VWT'($urandom);
    ch_mute = C'($urandom);
    tape    = 1'($urandom);
  endtask

  task automatic set_all(int dd, int vv, bit mm, bit tt);
    for (int i = 0; i < C; i++) begin d[i] = dd; v[i] = vv; m[i] = mm; end
    tp = tt;
  endtask

  task automatic mix_and_check(string tag);
    int e10 = ref_mix(10);
    int e8  = ref_mix(8);
    int lat = -1, vcnt = 0, bcnt = 0;
    apply();
    @(negedge clock); ce = 1'b1;
    @(negedge clock); ce = 1'b0;
    for (int c = 0; c < C + 6; c++) begin
      if (c == 0) scramble();
      if (busy) bcnt++;
      if (sample_valid) begin vcnt++; if (lat < 0) lat = c; end
      @(negedge clock);
    end
    chk({tag, "_latency"}, lat, C + 1);
    chk({tag, "_valid_count"}, vcnt, 1);
    chk({tag, "_busy_cycles"}, bcnt, C + 1);
    chk({tag, "_sample"}, sample, e10);
    chk({tag, "_sample_ow8"}, sample8, e8);
  endtask

  task automatic density_check(string tag, int n, int exp);
    int ones = 0;
    for (int c = 0; c < n; c++) begin
      if (q) ones++;
      @(negedge clock);
    end
    chk(tag, ones, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_sample", sample, 0);
    chk("rst_flags", {sample_valid, busy, overrun, q}, 0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);

    set_all(63, 15, 1'b0, 1'b1);
    mix_and_check("full");
    chk("full_no_overrun", overrun, 0);

    m[1] = 1'b1;
    mix_and_check("mute1");

    set_all(0, 0, 1'b1, 1'b0);
    d[0] = 40; v[0] = 8; m[0] = 1'b0;
    mix_and_check("trunc");
    repeat (2) @(negedge clock);
    density_check("sd_density_20", 1024, 20);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < C; i++) begin
        d[i] = int'($urandom_range(0, 63));
        v[i] = int'($urandom_range(0, 15));
        m[i] = ($urandom_range(0, 3) == 0);
      end
      tp = 1'($urandom);
      mix_and_check("rnd");
    end
    chk("rnd_no_overrun", overrun, 0);
    density_check("sd_density_rnd", 1024, ref_mix(10));

    // ce while busy, including on the DONE edge
    begin
      int lat = -1, vcnt = 0;
      set_all(63, 15, 1'b0, 1'b1);
      apply();
      @(negedge clock); ce = 1'b1;
      @(negedge clock); ce = 1'b0;
      for (int c = 0; c < C + 6; c++) begin
        if (sample_valid) begin vcnt++; if (lat < 0) lat = c; end
        ce = (c == 1 || c == C);
        @(negedge clock);
      end
      ce = 1'b0;
      chk("ovr_latency", lat, C + 1);
      chk("ovr_valid_count", vcnt, 1);
      chk("ovr_sample", sample, 299);
      chk("ovr_flag", overrun, 1);
      repeat (20) @(negedge clock);
      chk("ovr_sticky", overrun, 1);
    end

    // Asynchronous reset two cycles into a mix
    begin
      int vcnt = 0;
      apply();
      @(negedge clock); ce = 1'b1;
      @(negedge clock); ce = 1'b0;
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("arst_sample", sample, 0);
      chk("arst_sample_ow8", sample8, 0);
      chk("arst_flags", {sample_valid, busy, overrun, q}, 0);
      @(negedge clock); reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (sample_valid) vcnt++;
        @(negedge clock);
      end
      chk("arst_no_valid", vcnt, 0);
      density_check("sd_zero", 2048, 0);
      mix_and_check("post_rst");
      chk("post_rst_overrun", overrun, 0);
    end

    // Wide instance mixing to exactly 512: 239 + 239 + 34
    data_b = {8'd0, 8'd68, 8'd255, 8'd255};
    vol_b  = {4'd0, 4'd8, 4'd15, 4'd15};
    mute_b = 4'b1000;
    tape_b = 1'b0;
    @(negedge clock); ce_b = 1'b1;
    @(negedge clock); ce_b = 1'b0;
    repeat (10) @(negedge clock);
    chk("half_sample", sample_b, 512);
    begin
      int ones = 0, same = 0;
      logic prev = q_b;
      @(negedge clock);
      for (int c = 0; c < 1024; c++) begin
        if (q_b) ones++;
        if (q_b == prev) same++;
        prev = q_b;
        @(negedge clock);
      end
      chk("half_density", ones, 512);
      chk("half_alternate", same, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
